// File: rtl/expr_pkg.sv
// Shared definitions for the expression character generator.
// Holds ASCII byte constants, the operator bit encoding and the FSM state type.
// No ports; imported by expr_gen and expr_eval.
package expr_pkg;

  localparam logic [7:0] CH_0    = 8'h30;
  localparam logic [7:0] CH_PLUS = 8'h2B;
  localparam logic [7:0] CH_MUL  = 8'h2A;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_MUL = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DIGIT = 2'd1,
    S_OP    = 2'd2,
    S_FIN   = 2'd3
  } state_t;

endpackage

// File: rtl/expr_eval.sv
// Sum-of-products evaluator fed one operand per digit handshake ('*' binds tighter than '+').
// Ports: clk/clr, clear (request accepted), en (digit handshake), first/mul/last qualifiers,
//        digit (operand value), result (sum+prod, written on the final digit, held until clear).
// Only instantiated when EXPR_GEN_EVAL_EN is defined; arithmetic wraps modulo 2^RES_W.
module expr_eval
  import expr_pkg::*;
#(
  parameter int RES_W = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             clear,
  input  logic             en,
  input  logic             first,
  input  logic             mul,
  input  logic             last,
  input  logic [3:0]       digit,
  output logic [RES_W-1:0] result
);

  logic [RES_W-1:0] sum, prod;
  logic [RES_W-1:0] sum_n, prod_n;

  // Pending product absorbs '*' operands; a '+' commits it to the running sum.
  always_comb begin
    sum_n  = sum;
    prod_n = prod;
    if (first) begin
      prod_n = RES_W'(digit);
    end else if (mul) begin
      prod_n = prod * RES_W'(digit);
    end else begin
      sum_n  = sum + prod;
      prod_n = RES_W'(digit);
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sum    <= '0;
      prod   <= '0;
      result <= '0;
    end else if (clear) begin
      sum    <= '0;
      prod   <= '0;
      result <= '0;
    end else if (en) begin
      sum  <= sum_n;
      prod <= prod_n;
      if (last) begin
        result <= sum_n + prod_n;
      end
    end
  end

endmodule

// File: rtl/expr_gen.sv
// Serializes a packed expression (digits + '+'/'*' operators) into ASCII bytes, one per handshake.
// Ports: clk/clr, start/len/digits/ops request, busy, out_valid/out_ready/out_char/out_last stream,
//        done/err pulses, result (evaluated value only when EXPR_GEN_EVAL_EN is defined, else 0).
// First byte the cycle after acceptance; out_ready low holds the current byte stable.
module expr_gen
  import expr_pkg::*;
#(
  parameter  int MAX_N = 8,
  parameter  int RES_W = 32,
  localparam int LW    = $clog2(MAX_N + 1)
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               start,
  input  logic [LW-1:0]      len,
  input  logic [4*MAX_N-1:0] digits,
  input  logic [MAX_N-2:0]   ops,
  output logic               busy,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [7:0]         out_char,
  output logic               out_last,
  output logic               done,
  output logic               err,
  output logic [RES_W-1:0]   result
);

  state_t state, state_nxt;

  logic [LW-1:0]      len_q;
  logic [LW-1:0]      idx;
  logic [4*MAX_N-1:0] digits_q;
  logic [MAX_N-1:0]   ops_q;     // padded by one bit so it can be indexed like the digits
  logic               err_q;

  logic       req_ok;
  logic       accept;
  logic [3:0] cur_digit;
  logic       cur_op;
  logic       is_last;

  // Request is legal when 1 <= len <= MAX_N and every in-range digit is decimal.
  always_comb begin
    req_ok = (len != '0) && (len <= LW'(MAX_N));
    for (int i = 0; i < MAX_N; i++) begin
      if ((LW'(i) < len) && (digits[4*i +: 4] > 4'd9)) begin
        req_ok = 1'b0;
      end
    end
  end

  assign accept = (state == S_IDLE) && start && req_ok;

  // Operand/operator at the current index from the latched copy.
  always_comb begin
    cur_digit = 4'd0;
    cur_op    = OP_ADD;
    for (int i = 0; i < MAX_N; i++) begin
      if (idx == LW'(i)) begin
        cur_digit = digits_q[4*i +: 4];
        cur_op    = ops_q[i];
      end
    end
  end

  assign is_last = (idx == len_q - LW'(1));

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    out_valid = 1'b0;
    out_char  = 8'h00;
    out_last  = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) state_nxt = S_DIGIT;
      end
      S_DIGIT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_char  = CH_0 + {4'h0, cur_digit};
        out_last  = is_last;
        if (out_ready) state_nxt = is_last ? S_FIN : S_OP;
      end
      S_OP: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_char  = (cur_op == OP_MUL) ? CH_MUL : CH_PLUS;
        if (out_ready) state_nxt = S_DIGIT;
      end
      S_FIN: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      len_q    <= '0;
      idx      <= '0;
      digits_q <= '0;
      ops_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= (state == S_IDLE) && start && !req_ok;
      if (accept) begin
        len_q    <= len;
        digits_q <= digits;
        ops_q    <= {1'b0, ops};
        idx      <= '0;
      end else if ((state == S_OP) && out_ready) begin
        // Index advances after the operator so the next digit and ops[idx] line up.
        idx <= idx + LW'(1);
      end
    end
  end

  assign err = err_q;

`ifdef EXPR_GEN_EVAL_EN
  logic prev_op;

  // Operator to the left of the current digit decides multiply vs. add.
  always_comb begin
    prev_op = OP_ADD;
    for (int i = 1; i < MAX_N; i++) begin
      if (idx == LW'(i)) prev_op = ops_q[i-1];
    end
  end

  expr_eval #(.RES_W(RES_W)) u_eval (
    .clk    (clk),
    .clr    (clr),
    .clear  (accept),
    .en     ((state == S_DIGIT) && out_ready),
    .first  (idx == '0),
    .mul    (prev_op == OP_MUL),
    .last   (is_last),
    .digit  (cur_digit),
    .result (result)
  );
`else
  assign result = '0;
`endif

endmodule

// File: tb/tb_expr_gen.sv
module tb_expr_gen;

  localparam int MAX_N = 8;
  localparam int RES_W = 32;
  localparam int LW    = 4;

  logic               clk;
  logic               clr;
  logic               start;
  logic [LW-1:0]      len;
  logic [4*MAX_N-1:0] digits;
  logic [MAX_N-2:0]   ops;
  logic               busy;
  logic               out_valid;
  logic               out_ready;
  logic [7:0]         out_char;
  logic               out_last;
  logic               done;
  logic               err;
  logic [RES_W-1:0]   result;

  expr_gen #(.MAX_N(MAX_N), .RES_W(RES_W)) dut (
    .clk       (clk),
    .clr       (clr),
    .start     (start),
    .len       (len),
    .digits    (digits),
    .ops       (ops),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_char  (out_char),
    .out_last  (out_last),
    .done      (done),
    .err       (err),
    .result    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] ch;
    logic       last;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   errors   = 0;
  int   hs_count = 0;
  int   acc_hs   = 0;
  int   rdy_mode = 0;
  int   cyc      = 0;
  logic [3:0] pat = 4'b1001;   // ready pattern 1,0,0,1 repeating

  logic       stall_prev = 1'b0;
  logic [7:0] held_ch    = 8'h00;
  logic       held_last  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] c, input logic l);
    exp_q.push_back(exp_t'({c, l}));
  endtask

  // Monitor: pops the scoreboard on every handshake, and checks stalled bytes are held.
  always @(negedge clk) begin
    if (clr) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev)
        check("stall_hold", {out_valid, out_char, out_last}, {1'b1, held_ch, held_last});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got %0h, want no byte", out_char);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("byte", {out_char, out_last}, {e.ch, e.last});
        end
        hs_count++;
      end
      stall_prev = out_valid && !out_ready;
      held_ch    = out_char;
      held_last  = out_last;
    end
  end

  // Ready driver: always ready, or the 1,0,0,1 pattern when stalling is requested.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      out_ready = (rdy_mode == 0) ? 1'b1 : pat[cyc % 4];
    end
  end

  task automatic request(input int n, input logic [31:0] dg, input logic [6:0] op);
    start  = 1'b1;
    len    = n[LW-1:0];
    digits = dg;
    ops    = op;
    acc_hs = hs_count;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int exp_cycles, input int exp_hs,
                           input logic [31:0] exp_res);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done, want done within 200 cycles", name);
    end else begin
      if (exp_cycles >= 0) check({name, "_latency"}, n, exp_cycles);
      check({name, "_handshakes"}, hs_count - acc_hs, exp_hs);
      check({name, "_idle_outputs"}, {busy, out_valid}, 2'b00);
`ifdef EXPR_GEN_EVAL_EN
      check({name, "_result"}, result, exp_res);
`else
      check({name, "_result"}, result, 0);
`endif
      check({name, "_drained"}, exp_q.size(), 0);
      tick();
      check({name, "_done_pulse"}, done, 1'b0);
    end
  endtask

  task automatic bad_request(input string name, input int n, input logic [31:0] dg);
    start  = 1'b1;
    len    = n[LW-1:0];
    digits = dg;
    ops    = '0;
    tick();
    start = 1'b0;
    check({name, "_err"}, {err, out_valid, busy}, 3'b100);
    tick();
    check({name, "_err_clear"}, {err, out_valid, busy}, 3'b000);
  endtask

  initial begin
    clr    = 1'b1;
    start  = 1'b0;
    len    = '0;
    digits = '0;
    ops    = '0;
    #12;
    check("reset_outputs", {busy, out_valid, out_char, out_last, done, err, result},
          {1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0});
    tick();
    clr = 1'b0;
    tick();

    // "1+2*3" at full throughput.
    push("1", 0); push("+", 0); push("2", 0); push("*", 0); push("3", 1);
    request(3, 32'h0000_0321, 7'b000_0010);
    check("t1_first", {busy, out_valid, out_char}, {1'b1, 1'b1, 8'h31});
    wait_done("t1", 5, 5, 32'd7);

    // Same request with a stalling consumer.
    rdy_mode = 1;
    push("1", 0); push("+", 0); push("2", 0); push("*", 0); push("3", 1);
    request(3, 32'h0000_0321, 7'b000_0010);
    wait_done("t2", -1, 5, 32'd7);
    rdy_mode = 0;
    tick();

    // Single operand.
    push("9", 1);
    request(1, 32'h0000_0009, 7'b0);
    check("t3_first", {out_valid, out_char, out_last}, {1'b1, 8'h39, 1'b1});
    wait_done("t3", 1, 1, 32'd9);

    // Rejected requests.
    bad_request("len0", 0, 32'h0000_0000);
    bad_request("digit12", 2, 32'h0000_001C);
    bad_request("len9", 9, 32'h0000_0000);

    // Non-decimal digit beyond len is don't-care.
    push("3", 1);
    request(1, 32'h0000_00F3, 7'b0);
    wait_done("t4", 1, 1, 32'd3);

    // Reset mid-stream after two bytes, then "4*5".
    push("1", 0); push("+", 0);
    request(3, 32'h0000_0321, 7'b000_0010);
    tick();
    tick();
    clr = 1'b1;
    #1;
    check("clr_outputs", {busy, out_valid, out_char, out_last, done, err, result},
          {1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0});
    check("clr_drained", exp_q.size(), 0);
    tick();
    clr = 1'b0;
    tick();
    push("4", 0); push("*", 0); push("5", 1);
    request(2, 32'h0000_0054, 7'b000_0001);
    wait_done("t5", 3, 3, 32'd20);

    // Start while busy is ignored.
    push("1", 0); push("+", 0); push("2", 0); push("*", 0); push("3", 1);
    request(3, 32'h0000_0321, 7'b000_0010);
    start  = 1'b1;
    len    = 4'd2;
    digits = 32'h0000_0099;
    ops    = 7'b000_0001;
    tick();
    start = 1'b0;
    check("t6_no_err", err, 1'b0);
    wait_done("t6", -1, 5, 32'd7);
    check("t6_stays_idle", {busy, out_valid}, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
